ora_4bit_misr_core: RTL and testbench
=====================================

ORA_4BIT_MISR_CORE -- requirements
Module: ora_4bit_misr

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port: clock  input  1  rising-edge clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset; sampled only on the rising edge of clock.
REQ-004 Port: datain  input  2  per-cycle response word from the circuit under test: datain[0] = Sum, datain[1] = Cout.
REQ-005 Port: dataout_ora  output  4 (index range [4:1])  current MISR signature, bit 4 = MSB.
REQ-006 The block SHALL have no parameters.

Function
REQ-007 The block SHALL hold a 4-bit state register q[4:1] and drive dataout_ora directly from it, with no combinational path from datain.
REQ-008 The register SHALL implement an internal-XOR (Galois) MISR with characteristic polynomial x^4 + x + 1, using feedback tap q[4].
REQ-009 On each rising edge with reset = 0, the register SHALL update as follows:
- q1 <= q4 ^ datain[0]
- q2 <= q1 ^ q4 ^ datain[1]
- q3 <= q2
- q4 <= q3
REQ-010 The register SHALL update on every clock edge; there is no enable and no hold state.
REQ-011 Latency SHALL be one cycle: datain sampled at edge N is reflected in dataout_ora immediately after edge N.
REQ-012 With datain = 00, the MISR SHALL behave as a maximal-length LFSR: any nonzero state returns to itself after exactly 15 cycles, and state 0000 remains 0000.
REQ-013 The final signature SHALL be the value of dataout_ora after the last pattern edge; comparing it against a golden value is outside this block.
REQ-014 Signature aliasing SHALL be permitted and not flagged, i.e. the state may return to 0000 mid-sequence.

Reset
REQ-015 When reset = 1 at a rising clock edge, q[4:1] SHALL load 4'b0000, and datain SHALL be ignored on that edge.
REQ-016 Reset SHALL take priority over compaction on every edge, including when it is asserted mid-sequence.
REQ-017 A reset pulse between clock edges SHALL have no effect on the output.
REQ-018 Before the first reset edge, the output value SHALL be undefined; the bench SHALL apply reset before checking.
REQ-019 Compaction SHALL resume on the first edge after reset returns to 0.

Verification
REQ-020 Reset for 1 edge with datain = 11, then sample: dataout_ora = 0000.
REQ-021 After reset, apply datain over 7 edges as 01, 10, 11, 10, 10, 01, 01. dataout_ora SHALL read, in order: 0001, 0000, 0011, 0100, 1010, 0110, 1101.
REQ-022 After reset, apply datain = 01 for 1 edge, then 00. The sequence SHALL be 0001, 0010, 0100, 1000, 0011, and the state SHALL return to 0001 on the 15th edge after the first 0001.
REQ-023 After reset, hold datain = 00 for 20 edges: dataout_ora SHALL stay 0000 throughout.
REQ-024 Mid-sequence reset: reach 1010 via the REQ-021 stimulus, then assert reset for 1 edge with datain = 01 → 0000. Deassert reset and apply 01 → 0001.
REQ-025 Toggle reset high and low between two clock edges: dataout_ora SHALL remain unchanged.

Source files
------------

// File: rtl/ora_4bit_misr_core.sv
// 4-bit internal-XOR MISR output response analyser, polynomial x^4 + x + 1.
// Datain[0] is the adder Sum bit and datain[1] is the adder Cout bit.
module ora_4bit_misr_core (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] datain,
    output logic [4:1] dataout_ora
);

    logic [4:1] q_q;
    logic [4:1] q_d;

    // The feedback from q[4] enters the stage 1 XOR and the stage 2 XOR.
    always_comb begin
        q_d    = q_q;
        q_d[1] = q_q[4] ^ datain[0];
        q_d[2] = q_q[1] ^ q_q[4] ^ datain[1];
        q_d[3] = q_q[2];
        q_d[4] = q_q[3];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= 4'b0000;
        end else begin
            q_q <= q_d;
        end
    end

    assign dataout_ora = q_q;

endmodule

// File: tb/tb_ora_4bit_misr_core.sv
// Directed self-checking bench for ora_4bit_misr_core with hand-computed signatures.
module tb_ora_4bit_misr_core;

    logic       clock;
    logic       reset;
    logic [1:0] datain;
    logic [4:1] dataout_ora;

    int checks = 0;
    int errors = 0;

    ora_4bit_misr_core dut (
        .clock       (clock),
        .reset       (reset),
        .datain      (datain),
        .dataout_ora (dataout_ora)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive on the falling edge, then sample 1 time unit after the rising edge.
    task automatic step(input logic rst, input logic [1:0] d);
        @(negedge clock);
        reset  = rst;
        datain = d;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 2'b11);
        checks++;
        if (dataout_ora !== 4'b0000) begin
            errors++;
            $display("FAIL reset: got %b expected %b", dataout_ora, 4'b0000);
        end
    endtask

    task automatic test_vector_sequence();
        logic [1:0] vin [7]  = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10, 2'b01, 2'b01};
        logic [3:0] vexp [7] = '{4'b0001, 4'b0000, 4'b0011, 4'b0100,
                                 4'b1010, 4'b0110, 4'b1101};
        step(1'b1, 2'b00);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, vin[i]);
            checks++;
            if (dataout_ora !== vexp[i]) begin
                errors++;
                $display("FAIL vector_seq[%0d]: got %b expected %b", i, dataout_ora, vexp[i]);
            end
        end
    endtask

    task automatic test_lfsr_period();
        logic [3:0] seq [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                                 4'b0110, 4'b1100, 4'b1011, 4'b0101, 4'b1010,
                                 4'b0111, 4'b1110, 4'b1111, 4'b1101, 4'b1001};
        step(1'b1, 2'b00);
        step(1'b0, 2'b01);
        checks++;
        if (dataout_ora !== seq[0]) begin
            errors++;
            $display("FAIL lfsr_seed: got %b expected %b", dataout_ora, seq[0]);
        end
        for (int i = 1; i <= 15; i++) begin
            step(1'b0, 2'b00);
            checks++;
            if (dataout_ora !== seq[i % 15]) begin
                errors++;
                $display("FAIL lfsr_period[%0d]: got %b expected %b", i, dataout_ora, seq[i % 15]);
            end
        end
    endtask

    task automatic test_zero_hold();
        int bad = 0;
        step(1'b1, 2'b00);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 2'b00);
            checks++;
            if (dataout_ora !== 4'b0000) begin
                errors++;
                bad++;
                if (bad <= 3)
                    $display("FAIL zero_hold[%0d]: got %b expected %b", i, dataout_ora, 4'b0000);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [1:0] vin [5] = '{2'b01, 2'b10, 2'b11, 2'b10, 2'b10};
        step(1'b1, 2'b00);
        for (int i = 0; i < 5; i++) step(1'b0, vin[i]);
        checks++;
        if (dataout_ora !== 4'b1010) begin
            errors++;
            $display("FAIL mid_reset_pre: got %b expected %b", dataout_ora, 4'b1010);
        end
        step(1'b1, 2'b01);
        checks++;
        if (dataout_ora !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset_clear: got %b expected %b", dataout_ora, 4'b0000);
        end
        step(1'b0, 2'b01);
        checks++;
        if (dataout_ora !== 4'b0001) begin
            errors++;
            $display("FAIL mid_reset_resume: got %b expected %b", dataout_ora, 4'b0001);
        end
    endtask

    task automatic test_reset_glitch();
        step(1'b1, 2'b00);
        step(1'b0, 2'b11);
        // State 0011; pulse reset well away from any rising edge.
        @(negedge clock);
        datain = 2'b00;
        #1 reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (dataout_ora !== 4'b0011) begin
            errors++;
            $display("FAIL glitch_hold: got %b expected %b", dataout_ora, 4'b0011);
        end
        @(posedge clock);
        #1;
        checks++;
        if (dataout_ora !== 4'b0110) begin
            errors++;
            $display("FAIL glitch_next: got %b expected %b", dataout_ora, 4'b0110);
        end
    endtask

    task automatic test_back_to_back();
        step(1'b1, 2'b11);
        step(1'b0, 2'b11);
        checks++;
        if (dataout_ora !== 4'b0011) begin
            errors++;
            $display("FAIL b2b_first: got %b expected %b", dataout_ora, 4'b0011);
        end
        step(1'b0, 2'b11);
        checks++;
        if (dataout_ora !== 4'b0101) begin
            errors++;
            $display("FAIL b2b_second: got %b expected %b", dataout_ora, 4'b0101);
        end
    endtask

    initial begin
        reset  = 1'b1;
        datain = 2'b00;
        test_reset();
        test_vector_sequence();
        test_lfsr_period();
        test_zero_hold();
        test_mid_reset();
        test_reset_glitch();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
